// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk to a pixel tick and produces porch-inclusive 640x480@60 counters, syncs and the visible-window flag.
// Latency: counters advance on the edge where pixelTick is high; hSync/vSync/bright/frameStart are registered from the next counter values, so they have zero skew against hCount/vCount.
// Backpressure: none, free-running. Define VGA_FRAME_COUNT_EN to add the 16-bit frameCount output.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixelTick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frameStart
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frameCount
`endif
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW    = 10'(H_SYNC);
    localparam logic [9:0] V_SW    = 10'(V_SYNC);
    localparam logic [9:0] H_VS    = 10'(H_VIS_START);
    localparam logic [9:0] H_VE    = 10'(H_VIS_END);
    localparam logic [9:0] V_VS    = 10'(V_VIS_START);
    localparam logic [9:0] V_VE    = 10'(V_VIS_END);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             frame_start_q, frame_start_d;
    logic             pixel_tick;
    logic             h_wrap;

    assign pixel_tick = (div_q == DIV_LAST);
    assign h_wrap     = pixel_tick && (h_q == H_LAST);

    // Next-state: divider, raster counters and derived outputs from the next counter values.
    always_comb begin
        div_d         = pixel_tick ? '0 : div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (pixel_tick) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
        end
        if (h_wrap) begin
            v_d           = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            frame_start_d = (v_q == V_LAST);
        end
        hsync_d  = !(h_d < H_SW);
        vsync_d  = !(v_d < V_SW);
        bright_d = (h_d >= H_VS) && (h_d < H_VE) && (v_d >= V_VS) && (v_d < V_VE);
    end

    // State register; reset state corresponds to counters at (0,0) with no frame pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            bright_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter steps on the same edge that raises frameStart, so both are visible together.
    always_comb begin
        frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frameCount = frame_cnt_q;
`endif

    assign pixelTick  = pixel_tick;
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign bright     = bright_q;
    assign frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunk-raster instance is run across many frames with random resets,
// and a default-parameter instance is run over the first lines; both are compared every cycle
// against expected values computed arithmetically from the number of clocks since reset release.
module tb_vga_timing_gen;

    // Small raster: 3 clks/pixel, 20 pixels/line, 10 lines/frame -> 600 clks per frame.
    localparam int S_D = 3, S_HT = 20, S_HS = 3, S_HVS = 5, S_HVE = 17;
    localparam int S_VT = 10, S_VS = 2, S_VVS = 3, S_VVE = 9;
    localparam int N_CYCLES = 30000;

    typedef struct packed {
        logic        tick;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        br;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       s_tick, s_hs, s_vs, s_br, s_fs;
    logic [9:0] s_h, s_v;
    logic       d_tick, d_hs, d_vs, d_br, d_fs;
    logic [9:0] d_h, d_v;
    logic [15:0] s_fc, d_fc;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(S_D), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS), .H_VIS_END(S_HVE),
        .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS), .V_VIS_END(S_VVE)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pixelTick(s_tick), .hCount(s_h), .vCount(s_v),
        .hSync(s_hs), .vSync(s_vs), .bright(s_br), .frameStart(s_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frameCount(s_fc)
`endif
    );

    vga_timing_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .pixelTick(d_tick), .hCount(d_h), .vCount(d_v),
        .hSync(d_hs), .vSync(d_vs), .bright(d_br), .frameStart(d_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frameCount(d_fc)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign s_fc = 16'd0;
    assign d_fc = 16'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            if (err_cnt <= 30)
                $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs n clocks after reset release (n=0 is the reset state itself).
    function automatic exp_t ref_model(input int unsigned n, input int d, input int ht, input int hsw,
                                       input int hvs, input int hve, input int vt, input int vsw,
                                       input int vvs, input int vve);
        exp_t        e;
        int unsigned pix, line, frame_len, frames, h, v;
        pix       = n / d;
        line      = pix / ht;
        frame_len = d * ht * vt;
        frames    = n / frame_len;
        h         = pix % ht;
        v         = line % vt;
        e.tick = ((n % d) == d - 1);
        e.h    = h[9:0];
        e.v    = v[9:0];
        e.hs   = !(h < hsw);
        e.vs   = !(v < vsw);
        e.br   = (h >= hvs) && (h < hve) && (v >= vvs) && (v < vve);
        e.fs   = (n != 0) && ((n % frame_len) == 0);
        e.fc   = frames[15:0];
        return e;
    endfunction

    initial begin
        int unsigned n;
        int unsigned rst_left;
        int unsigned frames_seen;
        exp_t es, ed;
        n           = 0;
        rst_left    = 0;
        frames_seen = 0;

        rst_n = 1'b0;
        repeat (5) @(posedge clk);

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            es = ref_model(n, S_D, S_HT, S_HS, S_HVS, S_HVE, S_VT, S_VS, S_VVS, S_VVE);
            ed = ref_model(n, 4, 800, 96, 144, 784, 525, 2, 35, 515);

            chk("s.tick",   32'(s_tick), 32'(es.tick));
            chk("s.hcount", 32'(s_h),    32'(es.h));
            chk("s.vcount", 32'(s_v),    32'(es.v));
            chk("s.hsync",  32'(s_hs),   32'(es.hs));
            chk("s.vsync",  32'(s_vs),   32'(es.vs));
            chk("s.bright", 32'(s_br),   32'(es.br));
            chk("s.fstart", 32'(s_fs),   32'(es.fs));
`ifdef VGA_FRAME_COUNT_EN
            chk("s.fcount", 32'(s_fc),   32'(es.fc));
            chk("d.fcount", 32'(d_fc),   32'(ed.fc));
`endif
            chk("d.tick",   32'(d_tick), 32'(ed.tick));
            chk("d.hcount", 32'(d_h),    32'(ed.h));
            chk("d.vcount", 32'(d_v),    32'(ed.v));
            chk("d.hsync",  32'(d_hs),   32'(ed.hs));
            chk("d.vsync",  32'(d_vs),   32'(ed.vs));
            chk("d.bright", 32'(d_br),   32'(ed.br));
            chk("d.fstart", 32'(d_fs),   32'(ed.fs));
            if (es.fs) frames_seen++;

            // Reset schedule: one long clean run first, a forced mid-frame reset at a fixed
            // raster point, then sparse random resets of random length.
            if (rst_left != 0) begin
                rst_left--;
            end else if (cyc == 5000 && rst_n) begin
                rst_left = 0;
            end else if (cyc > 6000 && $urandom_range(0, 2499) == 0) begin
                rst_left = $urandom_range(1, 4);
            end
            if (cyc > 4000 && cyc < 6000 && rst_n && es.v == 10'd6 && es.h == 10'd7 && rst_left == 0
                && $urandom_range(0, 1) == 0) begin
                rst_left = 1;
            end
            rst_n = (rst_left == 0);
            if (!rst_n) rst_left = (rst_left > 0) ? rst_left - 1 : 0;

            @(posedge clk);
            n = rst_n ? n + 1 : 0;
        end

        chk("frames_seen_nonzero", 32'(frames_seen != 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
